// File: rtl/sevenseg_scan_ctl_pkg.sv
// Shared constants for the seven-segment scan controller: the active-low
// hex-to-segment table (bit 0 = segment a) and the all-dark pattern.
package sevenseg_pkg;

  localparam logic [6:0] SEG_OFF_N = 7'h7F;

  // Active-low glyphs for 0..F, index = hex value.
  localparam logic [6:0] HEX7_TABLE_N [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Table lookup wrapper so every user decodes the same way.
  function automatic logic [6:0] hex7_lookup_n(input logic [3:0] value);
    return HEX7_TABLE_N[value];
  endfunction

endpackage

// File: rtl/sevenseg_scan_ctl_if.sv
// Application-side bundle of the scan controller: load strobe, per-digit
// data and the board-facing active-low display pins.
interface sevenseg_scan_ctl_if #(
  parameter int NUM_DIGITS = 8,
  parameter int BRIGHT_W   = 3
);

  logic                    load;
  logic [4*NUM_DIGITS-1:0] hex_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank_in;
  logic [NUM_DIGITS-1:0]   blink_in;
  logic [BRIGHT_W-1:0]     bright;
  logic                    pending;
  logic                    frame_done;
  logic [6:0]              segs_n;
  logic                    dp_n;
  logic [NUM_DIGITS-1:0]   an_n;

  modport master (
    output load, hex_in, dp_in, blank_in, blink_in, bright,
    input  pending, frame_done, segs_n, dp_n, an_n
  );

  modport slave (
    input  load, hex_in, dp_in, blank_in, blink_in, bright,
    output pending, frame_done, segs_n, dp_n, an_n
  );

endinterface

// File: rtl/sevenseg_scan_ctl_hex7seg_n.sv
// Combinational 4-bit to active-low 7-segment decoder.
module hex7seg_n
  import sevenseg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] segs_n
);

  // Pure table lookup; every 4-bit value has a glyph.
  always_comb begin
    segs_n = hex7_lookup_n(hex);
  end

endmodule

// File: rtl/sevenseg_scan_ctl.sv
// Multiplexed N-digit seven-segment scanner with per-slot PWM brightness,
// per-digit blank/blink and shadow registers that only swap in at a frame
// wrap so a frame never shows a mix of old and new data.
module sevenseg_scan_ctl
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int TICK_DIV     = 1000,
  parameter int BRIGHT_W     = 3,
  parameter int BLINK_FRAMES = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  sevenseg_scan_ctl_if.slave bus
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DIG_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BLK_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [TICK_W-1:0]   TICK_LAST  = TICK_W'(TICK_DIV - 1);
  localparam logic [DIG_W-1:0]    DIG_LAST   = DIG_W'(NUM_DIGITS - 1);
  localparam logic [BLK_W-1:0]    BLK_LAST   = BLK_W'(BLINK_FRAMES - 1);
  localparam logic [BRIGHT_W-1:0] PHASE_LAST = {BRIGHT_W{1'b1}};

  // Scan state
  logic [TICK_W-1:0]   tick_cnt_r;
  logic [BRIGHT_W-1:0] phase_r;
  logic [DIG_W-1:0]    digit_r;
  logic [BLK_W-1:0]    blink_cnt_r;
  logic                blink_phase_r;
  logic                slot_start_r;
  logic [BRIGHT_W-1:0] bright_q_r;

  // Shadow (pending) and active display data
  logic [4*NUM_DIGITS-1:0] hex_pend_r,   hex_act_r;
  logic [NUM_DIGITS-1:0]   dp_pend_r,    dp_act_r;
  logic [NUM_DIGITS-1:0]   blank_pend_r, blank_act_r;
  logic [NUM_DIGITS-1:0]   blink_pend_r, blink_act_r;
  logic                    pending_r;

  // Registered pins
  logic                  frame_done_r;
  logic [6:0]            segs_n_r;
  logic                  dp_n_r;
  logic [NUM_DIGITS-1:0] an_n_r;

  // Combinational helpers
  logic                  tick_s;
  logic                  slot_end_s;
  logic                  wrap_s;
  logic [BRIGHT_W-1:0]   bright_eff_s;
  logic                  digit_on_s;
  logic [3:0]            hex_sel_s;
  logic [6:0]            seg_dec_s;
  logic [NUM_DIGITS-1:0] an_next_s;
  logic [6:0]            segs_next_s;
  logic                  dp_next_s;

  // Scan timing events derived from the counters.
  always_comb begin
    tick_s     = (tick_cnt_r == TICK_LAST);
    slot_end_s = tick_s && (phase_r == PHASE_LAST);
    wrap_s     = slot_end_s && (digit_r == DIG_LAST);
  end

  // Brightness is taken from the input on the first cycle of a slot and
  // from the held copy for the rest of it.
  always_comb begin
    if (slot_start_r) begin
      bright_eff_s = bus.bright;
    end else begin
      bright_eff_s = bright_q_r;
    end
  end

  // Decide whether the current digit is lit; the last tick of a slot is
  // always dark because phase all-ones can never be below bright.
  always_comb begin
    digit_on_s = (phase_r < bright_eff_s)
              && !blank_act_r[digit_r]
              && !(blink_act_r[digit_r] && blink_phase_r);
    hex_sel_s  = hex_act_r[{digit_r, 2'b00} +: 4];
  end

  hex7seg_n u_dec (
    .hex    (hex_sel_s),
    .segs_n (seg_dec_s)
  );

  // Next values for the display pins.
  always_comb begin
    an_next_s = {NUM_DIGITS{1'b1}};
    if (digit_on_s) begin
      an_next_s[digit_r] = 1'b0;
      segs_next_s        = seg_dec_s;
      dp_next_s          = ~dp_act_r[digit_r];
    end else begin
      segs_next_s = SEG_OFF_N;
      dp_next_s   = 1'b1;
    end
  end

  // Tick prescaler: one-cycle enable every TICK_DIV clocks.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_cnt_r <= '0;
    end else if (tick_s) begin
      tick_cnt_r <= '0;
    end else begin
      tick_cnt_r <= tick_cnt_r + TICK_W'(1);
    end
  end

  // Slot phase and digit index advance on ticks.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_r <= '0;
      digit_r <= '0;
    end else if (tick_s) begin
      phase_r <= phase_r + BRIGHT_W'(1);
      if (phase_r == PHASE_LAST) begin
        if (digit_r == DIG_LAST) begin
          digit_r <= '0;
        end else begin
          digit_r <= digit_r + DIG_W'(1);
        end
      end else begin
        digit_r <= digit_r;
      end
    end else begin
      phase_r <= phase_r;
      digit_r <= digit_r;
    end
  end

  // Track the first cycle of each slot and hold its brightness sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_start_r <= 1'b1;
      bright_q_r   <= '0;
    end else begin
      slot_start_r <= slot_end_s;
      bright_q_r   <= bright_eff_s;
    end
  end

  // Blink half-period counter, counted in whole frames.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blink_cnt_r   <= '0;
      blink_phase_r <= 1'b0;
    end else if (wrap_s) begin
      if (blink_cnt_r == BLK_LAST) begin
        blink_cnt_r   <= '0;
        blink_phase_r <= ~blink_phase_r;
      end else begin
        blink_cnt_r   <= blink_cnt_r + BLK_W'(1);
        blink_phase_r <= blink_phase_r;
      end
    end else begin
      blink_cnt_r   <= blink_cnt_r;
      blink_phase_r <= blink_phase_r;
    end
  end

  // Capture loads into the shadow registers; last load before a wrap wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hex_pend_r   <= '0;
      dp_pend_r    <= '0;
      blank_pend_r <= '0;
      blink_pend_r <= '0;
    end else if (bus.load) begin
      hex_pend_r   <= bus.hex_in;
      dp_pend_r    <= bus.dp_in;
      blank_pend_r <= bus.blank_in;
      blink_pend_r <= bus.blink_in;
    end else begin
      hex_pend_r   <= hex_pend_r;
      dp_pend_r    <= dp_pend_r;
      blank_pend_r <= blank_pend_r;
      blink_pend_r <= blink_pend_r;
    end
  end

  // Swap shadow into active at a frame wrap; a load landing on the wrap
  // cycle stays pending for the following frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hex_act_r   <= '0;
      dp_act_r    <= '0;
      blank_act_r <= '0;
      blink_act_r <= '0;
      pending_r   <= 1'b0;
    end else if (wrap_s && pending_r) begin
      hex_act_r   <= hex_pend_r;
      dp_act_r    <= dp_pend_r;
      blank_act_r <= blank_pend_r;
      blink_act_r <= blink_pend_r;
      pending_r   <= bus.load;
    end else begin
      hex_act_r   <= hex_act_r;
      dp_act_r    <= dp_act_r;
      blank_act_r <= blank_act_r;
      blink_act_r <= blink_act_r;
      pending_r   <= pending_r | bus.load;
    end
  end

  // Register all display pins and the frame pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_done_r <= 1'b0;
      an_n_r       <= {NUM_DIGITS{1'b1}};
      segs_n_r     <= SEG_OFF_N;
      dp_n_r       <= 1'b1;
    end else begin
      frame_done_r <= wrap_s;
      an_n_r       <= an_next_s;
      segs_n_r     <= segs_next_s;
      dp_n_r       <= dp_next_s;
    end
  end

  assign bus.pending    = pending_r;
  assign bus.frame_done = frame_done_r;
  assign bus.an_n       = an_n_r;
  assign bus.segs_n     = segs_n_r;
  assign bus.dp_n       = dp_n_r;

endmodule

// File: tb/tb_sevenseg_scan_ctl.sv
// Directed bench for sevenseg_scan_ctl: 4 digits, 2-clock tick, 4-tick
// slots (8 clks), 32-clock frames, blink half-period of 2 frames.
module tb_sevenseg_scan_ctl;

  localparam int ND = 4;
  localparam int TD = 2;
  localparam int BW = 2;
  localparam int BF = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;

  // Glyphs for hex 4321 on digits 0..3: 1,2,3,4
  logic [6:0] s4321 [4] = '{7'h79, 7'h24, 7'h30, 7'h19};

  always #5 clk = ~clk;

  sevenseg_scan_ctl_if #(.NUM_DIGITS(ND), .BRIGHT_W(BW)) bus_if ();

  sevenseg_scan_ctl #(
    .NUM_DIGITS(ND), .TICK_DIV(TD), .BRIGHT_W(BW), .BLINK_FRAMES(BF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
  endtask

  // Expected anodes for the output produced from scan state index c.
  function automatic logic [3:0] exp_an(int c, int br, logic [3:0] blank,
                                        logic [3:0] blink, bit bph);
    int ph;
    int d;
    logic [3:0] r;
    ph = (c / 2) % 4;
    d  = (c / 8) % 4;
    r  = 4'hF;
    if (ph < br && !blank[d] && !(blink[d] && bph)) r[d] = 1'b0;
    return r;
  endfunction

  function automatic int lit_idx(logic [3:0] an);
    case (an)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic test_reset();
    bus_if.load = 1'b0;
    bus_if.hex_in = 16'h0;
    bus_if.dp_in = 4'h0;
    bus_if.blank_in = 4'h0;
    bus_if.blink_in = 4'h0;
    bus_if.bright = 2'd3;
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    n_vec++;
    if (bus_if.an_n !== 4'hF) begin
      n_err++; $display("FAIL reset_an got=%b exp=1111", bus_if.an_n);
    end
    n_vec++;
    if (bus_if.segs_n !== 7'h7F) begin
      n_err++; $display("FAIL reset_segs got=%h exp=7f", bus_if.segs_n);
    end
    n_vec++;
    if (bus_if.dp_n !== 1'b1 || bus_if.pending !== 1'b0 || bus_if.frame_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_flags got dp_n=%b pending=%b fd=%b exp 1/0/0",
               bus_if.dp_n, bus_if.pending, bus_if.frame_done);
    end
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic test_idle_scan();
    logic [6:0] es;
    repeat (64) begin
      step();
      n_vec++;
      if (bus_if.an_n !== exp_an(cyc - 1, 3, 4'h0, 4'h0, 1'b0)) begin
        n_err++; $display("FAIL idle_an cyc=%0d got=%b exp=%b", cyc, bus_if.an_n,
                          exp_an(cyc - 1, 3, 4'h0, 4'h0, 1'b0));
      end
      es = (bus_if.an_n == 4'hF) ? 7'h7F : 7'h40;
      n_vec++;
      if (bus_if.segs_n !== es) begin
        n_err++; $display("FAIL idle_segs cyc=%0d got=%h exp=%h", cyc, bus_if.segs_n, es);
      end
      n_vec++;
      if (bus_if.dp_n !== 1'b1) begin
        n_err++; $display("FAIL idle_dp cyc=%0d got=%b exp=1", cyc, bus_if.dp_n);
      end
      n_vec++;
      if (bus_if.frame_done !== ((cyc % 32) == 0)) begin
        n_err++; $display("FAIL idle_frame_done cyc=%0d got=%b exp=%b", cyc,
                          bus_if.frame_done, (cyc % 32) == 0);
      end
    end
  endtask

  task automatic test_load();
    logic [6:0] es;
    int d;
    while (cyc < 74) step();
    bus_if.hex_in = 16'h4321;
    bus_if.load = 1'b1;
    step();
    bus_if.load = 1'b0;
    n_vec++;
    if (bus_if.pending !== 1'b1) begin
      n_err++; $display("FAIL load_pending_set got=%b exp=1", bus_if.pending);
    end
    while (cyc < 128) begin
      step();
      n_vec++;
      if (bus_if.an_n !== exp_an(cyc - 1, 3, 4'h0, 4'h0, 1'b0)) begin
        n_err++; $display("FAIL load_an cyc=%0d got=%b", cyc, bus_if.an_n);
      end
      d = lit_idx(bus_if.an_n);
      if (d < 0) es = 7'h7F;
      else if ((cyc - 1) / 32 == 2) es = 7'h40;
      else es = s4321[d];
      n_vec++;
      if (bus_if.segs_n !== es) begin
        n_err++; $display("FAIL load_segs cyc=%0d got=%h exp=%h", cyc, bus_if.segs_n, es);
      end
      n_vec++;
      if (bus_if.pending !== (cyc < 96)) begin
        n_err++; $display("FAIL load_pending cyc=%0d got=%b exp=%b", cyc, bus_if.pending, cyc < 96);
      end
    end
  endtask

  task automatic test_bright();
    int lows [4];
    for (int i = 0; i < 4; i++) lows[i] = 0;
    bus_if.bright = 2'd1;
    repeat (32) begin
      step();
      n_vec++;
      if (bus_if.an_n !== exp_an(cyc - 1, 1, 4'h0, 4'h0, 1'b0)) begin
        n_err++; $display("FAIL bright1_an cyc=%0d got=%b", cyc, bus_if.an_n);
      end
      for (int i = 0; i < 4; i++) if (bus_if.an_n[i] == 1'b0) lows[i]++;
    end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (lows[i] != 2) begin
        n_err++; $display("FAIL bright1_count digit=%0d got=%0d exp=2", i, lows[i]);
      end
    end
    bus_if.bright = 2'd0;
    repeat (32) begin
      step();
      n_vec++;
      if (bus_if.an_n !== 4'hF) begin
        n_err++; $display("FAIL bright0_dark cyc=%0d got=%b exp=1111", cyc, bus_if.an_n);
      end
    end
    bus_if.bright = 2'd3;
  endtask

  task automatic test_blank_dp();
    bus_if.blank_in = 4'b0100;
    bus_if.dp_in = 4'b0001;
    bus_if.load = 1'b1;
    step();
    bus_if.load = 1'b0;
    while (cyc < 224) step();
    n_vec++;
    if (bus_if.pending !== 1'b0) begin
      n_err++; $display("FAIL blank_pending_clear got=%b exp=0", bus_if.pending);
    end
    repeat (32) begin
      step();
      n_vec++;
      if (bus_if.an_n !== exp_an(cyc - 1, 3, 4'b0100, 4'h0, 1'b0) || bus_if.an_n[2] !== 1'b1) begin
        n_err++; $display("FAIL blank_an cyc=%0d got=%b", cyc, bus_if.an_n);
      end
      n_vec++;
      if (bus_if.dp_n !== (bus_if.an_n != 4'b1110)) begin
        n_err++; $display("FAIL dp cyc=%0d got=%b an=%b", cyc, bus_if.dp_n, bus_if.an_n);
      end
    end
  endtask

  task automatic test_blink();
    int lit_dark;
    int lit_on;
    bit bph;
    lit_dark = 0;
    lit_on = 0;
    do_reset();
    bus_if.blink_in = 4'b0001;
    bus_if.blank_in = 4'h0;
    bus_if.dp_in = 4'h0;
    bus_if.hex_in = 16'h4321;
    bus_if.load = 1'b1;
    step();
    bus_if.load = 1'b0;
    while (cyc < 32) step();
    repeat (160) begin
      step();
      bph = ((((cyc - 1) / 32) / 2) % 2) == 1;
      n_vec++;
      if (bus_if.an_n !== exp_an(cyc - 1, 3, 4'h0, 4'b0001, bph)) begin
        n_err++; $display("FAIL blink_an cyc=%0d got=%b", cyc, bus_if.an_n);
      end
      if (bus_if.an_n == 4'b1110) begin
        if (((cyc - 1) / 32) == 2 || ((cyc - 1) / 32) == 3) lit_dark++;
        if (((cyc - 1) / 32) == 4 || ((cyc - 1) / 32) == 5) lit_on++;
      end
    end
    n_vec++;
    if (lit_dark != 0 || lit_on != 12) begin
      n_err++; $display("FAIL blink_digit0 got dark_frames_lit=%0d lit_frames_lit=%0d exp 0/12",
                        lit_dark, lit_on);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] es;
    while (cyc < 200) step();
    bus_if.hex_in = 16'h8765;
    bus_if.blink_in = 4'h0;
    bus_if.load = 1'b1;
    step();
    bus_if.load = 1'b0;
    while (cyc < 223) step();
    bus_if.hex_in = 16'hBA98;
    bus_if.load = 1'b1;
    step();
    bus_if.load = 1'b0;
    n_vec++;
    if (bus_if.frame_done !== 1'b1 || bus_if.pending !== 1'b1) begin
      n_err++; $display("FAIL wrap_load got fd=%b pending=%b exp 1/1",
                        bus_if.frame_done, bus_if.pending);
    end
    step();
    step();
    n_vec++;
    if (bus_if.an_n !== 4'b1110 || bus_if.segs_n !== 7'h12) begin
      n_err++; $display("FAIL wrap_active got an=%b segs=%h exp 1110/12",
                        bus_if.an_n, bus_if.segs_n);
    end
    step();
    step();
    rst_n = 1'b0;
    step();
    n_vec++;
    if (bus_if.an_n !== 4'hF || bus_if.segs_n !== 7'h7F || bus_if.pending !== 1'b0) begin
      n_err++; $display("FAIL midreset got an=%b segs=%h pending=%b exp 1111/7f/0",
                        bus_if.an_n, bus_if.segs_n, bus_if.pending);
    end
    rst_n = 1'b1;
    cyc = 0;
    repeat (33) begin
      step();
      n_vec++;
      if (bus_if.an_n !== exp_an(cyc - 1, 3, 4'h0, 4'h0, 1'b0)) begin
        n_err++; $display("FAIL restart_an cyc=%0d got=%b", cyc, bus_if.an_n);
      end
      es = (bus_if.an_n == 4'hF) ? 7'h7F : 7'h40;
      n_vec++;
      if (bus_if.segs_n !== es || bus_if.pending !== 1'b0) begin
        n_err++; $display("FAIL restart_data cyc=%0d got segs=%h pending=%b exp %h/0",
                          cyc, bus_if.segs_n, bus_if.pending, es);
      end
      n_vec++;
      if (bus_if.frame_done !== (cyc == 32)) begin
        n_err++; $display("FAIL restart_frame_done cyc=%0d got=%b", cyc, bus_if.frame_done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_load();
    test_bright();
    test_blank_dp();
    test_blink();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan_ctl.md
Name: sevenseg_scan_ctl

Overview:
Parametrised multiplexed seven-segment display controller for N digits.
- Scans digits with a programmable refresh divider.
- Adds per-slot PWM brightness, per-digit blanking and blink, and frame-synchronous (tear-free) data loading through shadow registers.
- Sits between application logic and the board's active-low segment/anode pins.

Parameters:
- NUM_DIGITS, 8, number of digits scanned (1..8).
- TICK_DIV, 1000, clk cycles per PWM tick (>=1); the tick is a one-cycle enable.
- BRIGHT_W, 3, brightness width; a digit slot lasts 2**BRIGHT_W ticks.
- BLINK_FRAMES, 64, full scan frames per blink half-period (>=1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- load  in  1  one-cycle strobe; captures hex_in/dp_in/blank_in/blink_in into the pending registers.
- hex_in  in  4*NUM_DIGITS  hex value per digit; digit i occupies bits [4i+3:4i].
- dp_in  in  NUM_DIGITS  decimal point per digit; 1 = lit.
- blank_in  in  NUM_DIGITS  1 = digit fully dark.
- blink_in  in  NUM_DIGITS  1 = digit blinks.
- bright  in  BRIGHT_W  on-ticks per slot; sampled at slot start.
- pending  out  1  loaded data is waiting for a frame boundary.
- frame_done  out  1  one-cycle pulse when the digit index wraps to 0.
- segs_n  out  7  segments a..g, active-low; bit 0 = a.
- dp_n  out  1  decimal point, active-low.
- an_n  out  NUM_DIGITS  anodes, active-low; at most one low at any time.

Behaviour:
- Reset (rst_n=0 at posedge): all counters 0, digit=0, blink_phase=0, active and pending registers 0, pending=0, frame_done=0, an_n all 1, segs_n 7'h7F, dp_n=1.
- Tick divider: count 0..TICK_DIV-1. tick=1 on the cycle the count equals TICK_DIV-1, then the count wraps to 0.
- Slot phase counter (BRIGHT_W bits) advances on tick.
- On tick with phase = all-ones:
  - phase wraps to 0;
  - digit increments;
  - digit NUM_DIGITS-1 wraps to 0.
- Frame wrap event is the tick that moves digit from NUM_DIGITS-1 to 0. In that cycle:
  - frame_done=1 (registered, visible the following cycle);
  - the blink frame counter advances; when it reaches BLINK_FRAMES-1 it wraps and blink_phase toggles.
- bright_q captures bright when phase=0 and the slot starts; it is held for the whole slot.
- Digit i is on when all of the following hold:
  - digit == i;
  - phase < bright_q;
  - active blank bit i = 0;
  - NOT (active blink bit i AND blink_phase).
- Because phase can reach all-ones and bright_q is at most 2**BRIGHT_W-1, the last tick of every slot is always dark. This is the anti-ghosting guard.
- bright_q = 0 keeps the display dark.
- When no digit is on: an_n all 1, segs_n 7'h7F, dp_n=1.
- When a digit is on: segs_n = hex7 decode of the active hex for that digit; dp_n = ~dp.
- Outputs are registered: 1 clk latency from the counter state.
- Load handshake:
  - load=1 copies inputs into pending registers and sets pending=1.
  - At frame wrap with pending=1, active <= pending registers and pending clears.
  - load in the same cycle as the frame wrap: the active registers take the previous pending contents. The new data goes to pending, and pending stays 1 for the next frame.
  - Repeated loads before a wrap: the last one wins.
- Reset mid-scan: an_n all 1 on the next cycle and scanning restarts at digit 0, phase 0.
- NUM_DIGITS=1: every slot end is a frame wrap.

Decomposition:
- Package sevenseg_pkg holds:
  - the 16-entry hex-to-segment constant table (active-low, bit 0 = a);
  - a blank-pattern constant SEG_OFF_N = 7'h7F.
- One sub-module, hex7seg_n: combinational 4-bit to 7-bit active-low decoder using the package table.
- Everything else lives in sevenseg_scan_ctl.

Test Plan:
- Reset, then idle (NUM_DIGITS=4, TICK_DIV=2, BRIGHT_W=2, bright=3, nothing loaded) -> an_n cycles 1110,1101,1011,0111, each low for 6 clks then 2 clks dark; segs_n=7'h40 (hex 0); frame_done pulses every 32 clks.
- load with hex_in=16'h4321 mid-frame -> pending=1; digits still show 0 until the next frame_done; then digit0 shows 1 (7'h79), digit3 shows 4 (7'h19), and pending=0.
- bright=1 -> each digit is low for exactly 2 clks per slot. bright=0 -> an_n stays all 1 for a full frame.
- blank_in=4'b0100 and dp_in=4'b0001 loaded -> digit2 anode never low; dp_n=0 only while an_n=1110.
- blink_in=4'b0001, BLINK_FRAMES=2 -> digit0 dark during frames 2-3, lit during frames 4-5; other digits unaffected.
- load asserted on the frame-wrap cycle, then rst_n=0 for one cycle mid-slot -> the earlier pending data becomes active, the new data stays pending; after reset an_n=all 1, digit restarts at 0, pending=0.
